// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - SDRAM request/ack port bundle shared by requesters and the controller.
// The requester drives the request fields; the responder returns read data, ack and idle.
interface sdram_port_arbiter_if #(
  parameter int ADDR_BITS = 32
) ();
  logic [ADDR_BITS-1:0] addr;
  logic [15:0]          wr_data;
  logic [1:0]           wr_mask;
  logic                 we;
  logic                 enable;
  logic [15:0]          rd_data;
  logic                 ack;
  logic                 idle;

  modport master (
    output addr, wr_data, wr_mask, we, enable,
    input  rd_data, ack, idle
  );

  modport slave (
    input  addr, wr_data, wr_mask, we, enable,
    output rd_data, ack, idle
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port arbiter for the single SDRAM controller port (spi = port 0, usr = port 1).
// Define SDRAM_ARB_ANTISTARVE_EN to let usr win once after STARVE_LIMIT spi grants made while usr waited.
module sdram_port_arbiter #(
  parameter int ADDR_BITS    = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_port_arbiter_if.slave  spi,
  sdram_port_arbiter_if.slave  usr,
  sdram_port_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   aborted;
  logic   pick_usr;
  logic   grant;
  logic   owner_en;

`ifdef SDRAM_ARB_ANTISTARVE_EN
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 4) ? $clog2(STARVE_LIMIT + 1) : 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt;
`endif

  always_comb begin
    pick_usr = usr.enable && !spi.enable;
`ifdef SDRAM_ARB_ANTISTARVE_EN
    if (usr.enable && spi.enable && (starve_cnt >= LIMIT))
      pick_usr = 1'b1;
`endif
  end

  assign grant    = (state == IDLE) && mem.idle && (spi.enable || usr.enable);
  assign owner_en = owner ? usr.enable : spi.enable;

  // Idle is combinational so a requester sees the controller's own idle without delay.
  assign spi.idle = (state == IDLE) && mem.idle;
  assign usr.idle = (state == IDLE) && mem.idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      aborted     <= 1'b0;
      mem.addr    <= '0;
      mem.wr_data <= 16'h0000;
      mem.wr_mask <= 2'b00;
      mem.we      <= 1'b0;
      mem.enable  <= 1'b0;
      spi.ack     <= 1'b0;
      usr.ack     <= 1'b0;
      spi.rd_data <= 16'h0000;
      usr.rd_data <= 16'h0000;
`ifdef SDRAM_ARB_ANTISTARVE_EN
      starve_cnt  <= '0;
`endif
    end else begin
      spi.ack <= 1'b0;
      usr.ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner       <= pick_usr;
            aborted     <= 1'b0;
            mem.addr    <= pick_usr ? usr.addr    : spi.addr;
            mem.wr_data <= pick_usr ? usr.wr_data : spi.wr_data;
            mem.wr_mask <= pick_usr ? usr.wr_mask : spi.wr_mask;
            mem.we      <= pick_usr ? usr.we      : spi.we;
            mem.enable  <= 1'b1;
            state       <= BUSY;
`ifdef SDRAM_ARB_ANTISTARVE_EN
            if (pick_usr)
              starve_cnt <= '0;
            else if (usr.enable && (starve_cnt < LIMIT))
              starve_cnt <= starve_cnt + 1'b1;
`endif
          end
        end
        BUSY: begin
          // A dropped enable is remembered so a later re-raise cannot claim this result.
          if (!owner_en)
            aborted <= 1'b1;
          if (mem.ack) begin
            mem.enable <= 1'b0;
            if (aborted || !owner_en) begin
              state <= IDLE;
            end else begin
              if (owner) begin
                usr.ack     <= 1'b1;
                usr.rd_data <= mem.rd_data;
              end else begin
                spi.ack     <= 1'b1;
                spi.rd_data <= mem.rd_data;
              end
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!owner_en)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
